clz_norm_divider: RTL

- Multi-cycle DIV/DIVU unit for the multicycle MIPS datapath; produces the HI (remainder) and LO (quotient) write data.
- Drives the dividend magnitude into the combinational leading-zero counter and consumes its 0..32 count.
- Uses that count to pre-normalise the dividend, so only 32-clz restoring iterations run.
- Sits between the register-read operand latches and the HI/LO registers, under control-FSM start/done handshake.

---
 rtl/clz_norm_divider.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/clz_norm_divider.sv
// Multi-cycle signed/unsigned 32-bit divider for the multicycle MIPS datapath.
// The dividend is pre-normalised by an external leading-zero count, so only 32-clz restoring steps run.
module clz_norm_divider #(
  parameter logic [31:0] DIV0_QUOTIENT = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] clz_query,
  input  logic [5:0]  clz_count,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        div_by_zero
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PREP  = 3'd1,
    S_NORM  = 3'd2,
    S_ITER  = 3'd3,
    S_FIXUP = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic        sgn_q, sgn_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic        q_neg_q, q_neg_d;
  logic        r_neg_q, r_neg_d;
  logic [31:0] bmag_q, bmag_d;
  logic [31:0] dvd_q, dvd_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] clz_query_q, clz_query_d;
  logic [31:0] quotient_q, quotient_d;
  logic [31:0] remainder_q, remainder_d;
  logic        dz_q, dz_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [31:0] amag_s;
  logic [31:0] bmag_s;
  logic [32:0] shifted_s;
  logic [32:0] diff_s;

  // Next-state and datapath logic for the whole divide sequence
  always_comb begin
    state_d     = state_q;
    sgn_d       = sgn_q;
    a_d         = a_q;
    b_d         = b_q;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    bmag_d      = bmag_q;
    dvd_d       = dvd_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    cnt_d       = cnt_q;
    clz_query_d = clz_query_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dz_d        = dz_q;
    amag_s      = (sgn_q && a_q[31]) ? (32'd0 - a_q) : a_q;
    bmag_s      = (sgn_q && b_q[31]) ? (32'd0 - b_q) : b_q;
    shifted_s   = {rem_q, dvd_q[31]};
    diff_s      = shifted_s - {1'b0, bmag_q};

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          sgn_d   = is_signed;
          a_d     = dividend;
          b_d     = divisor;
          state_d = S_PREP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PREP: begin
        q_neg_d     = sgn_q & (a_q[31] ^ b_q[31]);
        r_neg_d     = sgn_q & a_q[31];
        clz_query_d = amag_s;
        bmag_d      = bmag_s;
        if (b_q == 32'd0) begin
          quotient_d  = DIV0_QUOTIENT;
          remainder_d = a_q;
          dz_d        = 1'b1;
          state_d     = S_DONE;
        end else begin
          state_d     = S_NORM;
        end
      end
      S_NORM: begin
        dvd_d = clz_query_q << clz_count;
        cnt_d = 6'd32 - clz_count;
        rem_d = 32'd0;
        quo_d = 32'd0;
        if (clz_count == 6'd32) begin
          state_d = S_FIXUP;
        end else begin
          state_d = S_ITER;
        end
      end
      S_ITER: begin
        // Borrow out of the 33-bit subtraction means the partial remainder is below the divisor.
        if (!diff_s[32]) begin
          rem_d = diff_s[31:0];
          quo_d = {quo_q[30:0], 1'b1};
        end else begin
          rem_d = shifted_s[31:0];
          quo_d = {quo_q[30:0], 1'b0};
        end
        dvd_d = {dvd_q[30:0], 1'b0};
        cnt_d = cnt_q - 6'd1;
        if (cnt_q == 6'd1) begin
          state_d = S_FIXUP;
        end else begin
          state_d = S_ITER;
        end
      end
      S_FIXUP: begin
        quotient_d  = q_neg_q ? (32'd0 - quo_q) : quo_q;
        remainder_d = r_neg_q ? (32'd0 - rem_q) : rem_q;
        dz_d        = 1'b0;
        state_d     = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_PREP) || (state_d == S_NORM) ||
             (state_d == S_ITER) || (state_d == S_FIXUP);
    done_d = (state_d == S_DONE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      sgn_q       <= 1'b0;
      a_q         <= 32'd0;
      b_q         <= 32'd0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      bmag_q      <= 32'd0;
      dvd_q       <= 32'd0;
      rem_q       <= 32'd0;
      quo_q       <= 32'd0;
      cnt_q       <= 6'd0;
      clz_query_q <= 32'd0;
      quotient_q  <= 32'd0;
      remainder_q <= 32'd0;
      dz_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sgn_q       <= sgn_d;
      a_q         <= a_d;
      b_q         <= b_d;
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
      bmag_q      <= bmag_d;
      dvd_q       <= dvd_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      cnt_q       <= cnt_d;
      clz_query_q <= clz_query_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dz_q        <= dz_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign clz_query   = clz_query_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dz_q;

endmodule
